// File: rtl/seg_scan_ctrl.sv
// Two-module, 8-digit hex scan controller with a frame-aligned one-entry load buffer.
// Optional leading-zero blanking per module when SEG_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        frame_done,
  output logic [7:0]  D0_SEG,
  output logic [3:0]  D0_AN,
  output logic [7:0]  D1_SEG,
  output logic [3:0]  D1_AN
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0] pre;
  logic [1:0]       dig;
  logic [31:0]      shadow;
  logic [31:0]      pend;
  logic             pend_full;

  logic             tick;
  logic             boundary;
  logic             accept;
  logic [7:0]       d0_seg_nxt;
  logic [7:0]       d1_seg_nxt;
  logic [3:0]       an_nxt;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Segment pattern for slot k of one 16-bit module word.
  function automatic logic [7:0] slot_seg(input logic [15:0] half, input logic [1:0] k);
    logic [3:0] nib;
    nib = half[{k, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    if (k != 2'd0 && (half >> {k, 2'b00}) == 16'h0000)
      return 8'hFF;
`endif
    return hex_seg(nib);
  endfunction

  assign tick       = (pre == PRE_W'(CLK_DIV - 1));
  assign boundary   = tick && (dig == 2'd3);
  assign load_ready = ~pend_full;
  assign accept     = load_valid && load_ready;

  assign d0_seg_nxt = slot_seg(shadow[15:0],  dig);
  assign d1_seg_nxt = slot_seg(shadow[31:16], dig);
  assign an_nxt     = ~(4'b0001 << dig);

  // NOTE: all state here updates with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre        <= '0;
      dig        <= 2'd0;
      shadow     <= 32'h0;
      pend_full  <= 1'b0;
      frame_done <= 1'b0;
      D0_SEG     <= 8'hFF;
      D1_SEG     <= 8'hFF;
      D0_AN      <= 4'hF;
      D1_AN      <= 4'hF;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick)
        dig <= dig + 2'd1;

      // Commit and accept are exclusive: accept needs an empty slot, commit a full one.
      if (boundary && pend_full) begin
        shadow    <= pend;
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
      end

      frame_done <= boundary;
      D0_SEG     <= d0_seg_nxt;
      D1_SEG     <= d1_seg_nxt;
      D0_AN      <= an_nxt;
      D1_AN      <= an_nxt;
    end
  end

  // NOTE: the pending payload is deliberately left out of reset; pend_full alone
  // qualifies it, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept)
      pend <= data_in;
  end

endmodule
